// File: rtl/apb_ram_ws.sv
// apb_ram_ws: APB completer backed by a DEPTH-word RAM with configurable wait states.
//
// Ports:
//   PCLK, PRESETn         clock (rising edge) and asynchronous active-low reset
//   PSEL, PENABLE         APB select and access-phase indicator
//   PWRITE, PADDR, PWDATA transfer direction, byte address, write data
//   PSTRB                 byte-lane write strobes (only when APB_RAM_PSTRB_EN is defined)
//   PRDATA, PREADY        read data (zero outside a read completion) and completion flag
//   PSLVERR               error flag: out-of-range or misaligned address, qualified by PREADY
//
// Build option: define APB_RAM_PSTRB_EN to add the PSTRB port and per-lane writes.
// Without it every write updates the full word.
//
// All outputs come from registered state and the setup-phase copy of the transfer;
// nothing on the bus reaches an output combinationally.
module apb_ram_ws #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_RAM_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned OffW     = $clog2(NumBytes);
  localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] AlignMask = ADDR_WIDTH'((64'd1 << OffW) - 64'd1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NumBytes-1:0]   strb_q, strb_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  addr_err;
  logic                  setup;
  logic                  ready;
  logic                  complete;
  logic [NumBytes-1:0]   bus_strb;

  assign word_idx = PADDR >> OffW;
  // Error is resolved at setup time so the access phase only needs the latched flag.
  assign addr_err = (64'(word_idx) >= 64'(DEPTH)) || ((PADDR & AlignMask) != '0);
  assign setup    = PSEL && !PENABLE;
  assign ready    = (state_q == StAccess) && (cnt_q == 8'd0);
  assign complete = ready && PSEL && PENABLE;

`ifdef APB_RAM_PSTRB_EN
  assign bus_strb = PSTRB;
`else
  assign bus_strb = '1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    case (state_q)
      // DONE behaves like IDLE for a new setup phase, giving 2-cycle back-to-back transfers.
      StIdle, StDone: begin
        state_d = StIdle;
        if (setup) begin
          state_d = StAccess;
          cnt_d   = 8'(WAIT_CYCLES);
          idx_d   = word_idx[IdxW-1:0];
          write_d = PWRITE;
          err_d   = addr_err;
          wdata_d = PWDATA;
          strb_d  = bus_strb;
        end
      end
      StAccess: begin
        if (!PSEL) begin
          state_d = StIdle;
        end else if (complete) begin
          state_d = StDone;
        end else if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      idx_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
    end
  end

  // Storage is intentionally not reset; state_q is IDLE during reset so nothing commits.
  always_ff @(posedge PCLK) begin
    if (complete && write_q && !err_q) begin
      for (int i = 0; i < int'(NumBytes); i++) begin
        if (strb_q[i]) begin
          mem[idx_q][i*8 +: 8] <= wdata_q[i*8 +: 8];
        end
      end
    end
  end

  assign PREADY  = ready;
  assign PSLVERR = ready && err_q;
  assign PRDATA  = (ready && !write_q && !err_q) ? mem[idx_q] : '0;

endmodule

// File: tb/tb_apb_ram_ws.sv
// Bench for apb_ram_ws: four instances with WAIT_CYCLES = 0..3 on a shared bus,
// each with its own PSEL. Directed transfers with hand-computed expectations.
module tb_apb_ram_ws;

  localparam int NumDut = 4;

  logic              pclk = 1'b0;
  logic              presetn;
  logic [NumDut-1:0] psel;
  logic              penable;
  logic              pwrite;
  logic [31:0]       paddr;
  logic [31:0]       pwdata;
`ifdef APB_RAM_PSTRB_EN
  logic [3:0]        pstrb;
`endif
  logic [31:0]       prdata [NumDut];
  logic [NumDut-1:0] pready;
  logic [NumDut-1:0] pslverr;

  int checks   = 0;
  int failures = 0;

  always #5 pclk = ~pclk;

  for (genvar g = 0; g < NumDut; g++) begin : g_dut
    apb_ram_ws #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .DEPTH      (64),
      .WAIT_CYCLES(g)
    ) u_dut (
      .PCLK   (pclk),
      .PRESETn(presetn),
      .PSEL   (psel[g]),
      .PENABLE(penable),
      .PWRITE (pwrite),
      .PADDR  (paddr),
      .PWDATA (pwdata),
`ifdef APB_RAM_PSTRB_EN
      .PSTRB  (pstrb),
`endif
      .PRDATA (prdata[g]),
      .PREADY (pready[g]),
      .PSLVERR(pslverr[g])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full transfer to instance d. Starts just after a rising edge and returns
  // 1ns after the completion edge with PSEL low, so an immediate next call is back-to-back.
  task automatic apb_xfer(input int d, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int waits, output int cycles,
                          output bit idle_bad);
    bit done;
    done     = 1'b0;
    waits    = 0;
    cycles   = 1;
    idle_bad = 1'b0;
    rdata    = '0;
    err      = 1'b0;
    psel     = '0;
    psel[d]  = 1'b1;
    penable  = 1'b0;
    pwrite   = wr;
    paddr    = addr;
    pwdata   = wdata;
    @(posedge pclk); #1;
    penable = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge pclk);
      cycles++;
      if (pready[d]) begin
        rdata = prdata[d];
        err   = pslverr[d];
        done  = 1'b1;
      end else begin
        waits++;
        if (prdata[d] != '0 || pslverr[d]) idle_bad = 1'b1;
      end
      @(posedge pclk); #1;
    end
    psel    = '0;
    penable = 1'b0;
    if (!done) check_eq("xfer_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          w;
    int          c;
    bit          ib;

    presetn = 1'b0;
    psel    = '0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
`ifdef APB_RAM_PSTRB_EN
    pstrb   = 4'hF;
`endif
    repeat (2) @(posedge pclk);
    #1;
    check_eq("rst_pready", 32'(pready), 32'd0);
    check_eq("rst_pslverr", 32'(pslverr), 32'd0);
    check_eq("rst_prdata0", prdata[0], 32'd0);
    check_eq("rst_prdata3", prdata[3], 32'd0);
    presetn = 1'b1;
    @(posedge pclk); #1;

    // PSEL+PENABLE seen in IDLE must be ignored.
    psel[0] = 1'b1;
    penable = 1'b1;
    paddr   = 32'h4;
    @(posedge pclk); #1;
    check_eq("proto_viol_pready", 32'(pready[0]), 32'd0);
    psel    = '0;
    penable = 1'b0;
    @(posedge pclk); #1;

    // Zero-wait write then read.
    apb_xfer(0, 1'b1, 32'h04, 32'hA5A5_A5A5, rd, er, w, c, ib);
    check_eq("zw_wr_waits", 32'(w), 32'd0);
    check_eq("zw_wr_err", 32'(er), 32'd0);
    apb_xfer(0, 1'b0, 32'h04, 32'h0, rd, er, w, c, ib);
    check_eq("zw_rd_waits", 32'(w), 32'd0);
    check_eq("zw_rd_data", rd, 32'hA5A5_A5A5);
    check_eq("zw_rd_err", 32'(er), 32'd0);

    // Two wait states.
    apb_xfer(2, 1'b1, 32'h08, 32'h0BAD_F00D, rd, er, w, c, ib);
    check_eq("ws_wr_waits", 32'(w), 32'd2);
    apb_xfer(2, 1'b0, 32'h08, 32'h0, rd, er, w, c, ib);
    check_eq("ws_rd_waits", 32'(w), 32'd2);
    check_eq("ws_rd_idle_zero", 32'(ib), 32'd0);
    check_eq("ws_rd_data", rd, 32'h0BAD_F00D);
    check_eq("ws_rd_err", 32'(er), 32'd0);

    // Errors: out-of-range write must not alias onto word 0; misaligned read.
    apb_xfer(0, 1'b1, 32'h00, 32'h0102_0304, rd, er, w, c, ib);
    apb_xfer(0, 1'b1, 32'h100, 32'hCAFE_F00D, rd, er, w, c, ib);
    check_eq("oor_wr_err", 32'(er), 32'd1);
    apb_xfer(0, 1'b0, 32'h00, 32'h0, rd, er, w, c, ib);
    check_eq("oor_mem_unchanged", rd, 32'h0102_0304);
    apb_xfer(0, 1'b0, 32'h02, 32'h0, rd, er, w, c, ib);
    check_eq("mis_rd_data", rd, 32'd0);
    check_eq("mis_rd_err", 32'(er), 32'd1);
    apb_xfer(0, 1'b1, 32'hFC, 32'h89AB_CDEF, rd, er, w, c, ib);
    check_eq("last_wr_err", 32'(er), 32'd0);
    apb_xfer(0, 1'b0, 32'hFC, 32'h0, rd, er, w, c, ib);
    check_eq("last_rd_data", rd, 32'h89AB_CDEF);
    apb_xfer(0, 1'b0, 32'h100, 32'h0, rd, er, w, c, ib);
    check_eq("oor_rd_data", rd, 32'd0);
    check_eq("oor_rd_err", 32'(er), 32'd1);

`ifdef APB_RAM_PSTRB_EN
    apb_xfer(0, 1'b1, 32'h0C, 32'hFFFF_FFFF, rd, er, w, c, ib);
    pstrb = 4'b0101;
    apb_xfer(0, 1'b1, 32'h0C, 32'h1234_5678, rd, er, w, c, ib);
    pstrb = 4'b0000;
    apb_xfer(0, 1'b1, 32'h0C, 32'h0000_0000, rd, er, w, c, ib);
    check_eq("strb0_err", 32'(er), 32'd0);
    pstrb = 4'b0000;
    apb_xfer(0, 1'b0, 32'h0C, 32'h0, rd, er, w, c, ib);
    check_eq("strb_rd_data", rd, 32'hFF34_FF78);
    pstrb = 4'hF;
`endif

    // Abort: PSEL dropped during the access phase of a 1-wait write.
    apb_xfer(1, 1'b1, 32'h20, 32'h5555_5555, rd, er, w, c, ib);
    psel[1] = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h20;
    pwdata  = 32'h6666_6666;
    @(posedge pclk); #1;
    psel = '0;
    @(posedge pclk); #1;
    apb_xfer(1, 1'b0, 32'h20, 32'h0, rd, er, w, c, ib);
    check_eq("abort_no_write", rd, 32'h5555_5555);

    // Back-to-back zero-wait writes, 2 cycles each.
    for (int i = 0; i < 4; i++) begin
      apb_xfer(0, 1'b1, 32'h40 + 32'(4 * i), 32'h1000_0000 * 32'(i + 1) + 32'(i), rd, er, w, c, ib);
      check_eq($sformatf("b2b_cycles_%0d", i), 32'(c), 32'd2);
    end
    for (int i = 0; i < 4; i++) begin
      apb_xfer(0, 1'b0, 32'h40 + 32'(4 * i), 32'h0, rd, er, w, c, ib);
      check_eq($sformatf("b2b_rd_%0d", i), rd, 32'h1000_0000 * 32'(i + 1) + 32'(i));
    end

    // Reset in the second access cycle of a 3-wait write.
    apb_xfer(3, 1'b1, 32'h10, 32'h1111_1111, rd, er, w, c, ib);
    psel[3] = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h10;
    pwdata  = 32'hDEAD_BEEF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    presetn = 1'b0;
    #1;
    check_eq("midrst_pready", 32'(pready[3]), 32'd0);
    check_eq("midrst_pslverr", 32'(pslverr[3]), 32'd0);
    check_eq("midrst_prdata", prdata[3], 32'd0);
    @(posedge pclk); #1;
    psel    = '0;
    penable = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    @(posedge pclk); #1;
    apb_xfer(3, 1'b0, 32'h10, 32'h0, rd, er, w, c, ib);
    check_eq("midrst_rd_waits", 32'(w), 32'd3);
    check_eq("midrst_rd_data", rd, 32'h1111_1111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_ram_ws.md
# apb_ram_ws

Parametrised APB RAM completer: a DEPTH-word memory behind an APB slave port with a configurable number of wait states, address-range and alignment error reporting, and optional byte-lane write strobes. It is the next generation of the team's fixed-size APB memory slave. It sits on the APB bus as a peripheral and is the standard memory target for APB bus benches and integration tests.

## Interface
- ADDR_WIDTH, 32, PADDR width in bits
- DATA_WIDTH, 32, data width; must be 8, 16, 32 or 64
- DEPTH, 64, number of DATA_WIDTH words; 2..2^(ADDR_WIDTH-log2(DATA_WIDTH/8))
- WAIT_CYCLES, 0, access-phase cycles with PREADY low before completion; 0..255
- PCLK  in  1  clock; everything is on the rising edge
- PRESETn  in  1  asynchronous, active-low reset
- PSEL  in  1  completer select
- PENABLE  in  1  access-phase indicator
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDR_WIDTH  byte address
- PWDATA  in  DATA_WIDTH  write data
- PSTRB  in  DATA_WIDTH/8  byte-lane write strobes; present only with APB_RAM_PSTRB_EN
- PRDATA  out  DATA_WIDTH  read data
- PREADY  out  1  transfer completion
- PSLVERR  out  1  transfer error; qualified by PREADY

## Operation
- Byte address PADDR maps to word index idx = PADDR >> log2(DATA_WIDTH/8).
- Error conditions:
  - idx >= DEPTH;
  - PADDR low log2(DATA_WIDTH/8) bits nonzero (misaligned).
- FSM has three states: IDLE, ACCESS and DONE.
- IDLE:
  - Sampling PSEL=1 and PENABLE=0 (setup phase) latches PADDR, PWRITE, PWDATA and PSTRB, loads wait counter cnt=WAIT_CYCLES, and moves to ACCESS.
  - Sampling PSEL=1 and PENABLE=1 in IDLE is a protocol violation: ignore it and stay in IDLE.
- ACCESS:
  - PREADY = (cnt==0). While cnt>0 and PSEL=1, decrement cnt each cycle.
  - At the edge where PSEL, PENABLE and PREADY are all 1: commit the write (unless error) and go to DONE.
  - PSEL=0 sampled in ACCESS is an abort: return to IDLE, no memory change.
- DONE: one-cycle turnaround, then IDLE. If a setup phase is sampled in DONE, treat it as in IDLE (latch and go to ACCESS), so back-to-back zero-wait transfers take 2 cycles each.
- Transfer controls (address, direction, write data, strobes) are taken from the latched setup-phase copy. Changes on the bus during ACCESS are ignored.
- Write:
  - No error: mem[idx] lanes updated per strobe.
  - Error: memory unchanged, PSLVERR=1 in the completion cycle.
- Read:
  - PRDATA = mem[idx] during the completion cycle.
  - Error: PRDATA = 0 with PSLVERR=1.
  - PRDATA = 0 in all other cycles.
- PSLVERR is 0 whenever PREADY is 0.
- Memory contents are not reset and are X until written.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, cnt=0, PREADY=0, PSLVERR=0, PRDATA=0. Reset during ACCESS aborts the transfer; a pending write is not committed.
- Setup cycle is T0. The first access cycle is T1. PREADY rises in cycle T1+WAIT_CYCLES.
- Write data is visible to a read whose setup phase starts at the earliest legal cycle after completion (no read-after-write hazard).
- PREADY, PSLVERR and PRDATA are driven from registered state and latched values only. There is no combinational path from PADDR, PWRITE or PWDATA to any output.
- cnt is 8 bits and never underflows; it holds at 0.

## Configuration
- APB_RAM_PSTRB_EN defined:
  - PSTRB port present; byte lane i is written only if PSTRB[i]=1.
  - A write with PSTRB=0 completes without error and leaves memory unchanged.
  - PSTRB is ignored on reads.
- APB_RAM_PSTRB_EN undefined: PSTRB port absent; every write updates the full word.

## Test plan
- Reset mid-wait, WAIT_CYCLES=3: drop PRESETn in the second access cycle of a write of 0xDEADBEEF to 0x10. Require outputs 0 immediately. After reset release, a read of 0x10 returns the prior value (0x11111111 preloaded).
- Zero-wait write/read, WAIT_CYCLES=0: write 0xA5A5A5A5 to 0x04, then read 0x04. Require PREADY high in T1 of each transfer, PRDATA=0xA5A5A5A5, PSLVERR=0.
- Wait states, WAIT_CYCLES=2: a read of 0x08 gives PREADY low for 2 access cycles, then high for 1. PRDATA=0 until that cycle.
- Errors, DEPTH=64: write to 0x100 completes with PSLVERR=1 and memory unchanged. Read of 0x02 (misaligned) returns PRDATA=0, PSLVERR=1.
- Strobes, APB_RAM_PSTRB_EN: write 0xFFFFFFFF, then write 0x12345678 with PSTRB=0b0101 to 0x0C. Read returns 0xFF34FF78.
- Abort and back-to-back: deassert PSEL in ACCESS (WAIT_CYCLES=1); require no write. Then issue 4 consecutive zero-wait writes; each completes in 2 cycles and reads back correctly.
